// File: rtl/std_fp_sdiv_pipe.sv
// Iterative signed fixed-point divider, one restoring step per cycle, go/done handshake.
// Optional error flag output enabled by defining STD_FP_SDIV_ERR_EN.
module std_fp_sdiv_pipe #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned INT_WIDTH   = 16,
  parameter int unsigned FRACT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
`ifdef STD_FP_SDIV_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned ITERS = WIDTH + FRACT_WIDTH;
  localparam int unsigned CntW  = $clog2(ITERS + 1);

  if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_bad_cfg
    $error("INT_WIDTH + FRACT_WIDTH must equal WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [ITERS-1:0]  dvd_q;  // dividend bits leave at the top, quotient bits enter at the bottom
  logic [WIDTH:0]    dvs_q;
  logic [WIDTH:0]    rem_q;
  logic [CntW-1:0]   cnt_q;
  logic              quot_neg_q;
  logic              rem_neg_q;
  logic [WIDTH-1:0]  left_q;
  logic [WIDTH-1:0]  quot_q;
  logic [WIDTH-1:0]  remd_q;
  logic              done_q;

  logic [WIDTH-1:0]  left_mag;
  logic [WIDTH-1:0]  right_mag;
  logic [WIDTH+1:0]  rem_shift;
  logic [WIDTH:0]    rem_sub;
  logic              take;
  logic [WIDTH:0]    rem_nxt;
  logic [ITERS-1:0]  quo_nxt;
  logic              div_zero;
  logic [WIDTH-1:0]  quo_signed;
  logic [WIDTH-1:0]  rem_signed;
  logic [WIDTH-1:0]  res_quot;
  logic [WIDTH-1:0]  res_rem;

  always_comb begin
    left_mag   = left[WIDTH-1] ? (~left + 1'b1) : left;
    right_mag  = right[WIDTH-1] ? (~right + 1'b1) : right;
    rem_shift  = {rem_q, dvd_q[ITERS-1]};
    take       = (rem_shift >= {1'b0, dvs_q});
    rem_sub    = rem_shift[WIDTH:0] - dvs_q;
    rem_nxt    = take ? rem_sub : rem_shift[WIDTH:0];
    quo_nxt    = {dvd_q[ITERS-2:0], take};
    div_zero   = (dvs_q == '0);
    quo_signed = quot_neg_q ? (~quo_nxt[WIDTH-1:0] + 1'b1) : quo_nxt[WIDTH-1:0];
    rem_signed = rem_neg_q ? (~rem_nxt[WIDTH-1:0] + 1'b1) : rem_nxt[WIDTH-1:0];
    if (div_zero) begin
      // Saturate toward the dividend's sign; the restoring datapath result is meaningless here.
      res_quot = left_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      res_rem  = left_q;
    end else begin
      res_quot = quo_signed;
      res_rem  = rem_signed;
    end
  end

`ifdef STD_FP_SDIV_ERR_EN
  localparam logic [ITERS-1:0] QuotNegMax = {{(ITERS - WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  logic err_q;
  logic hi_zero;
  logic res_err;

  always_comb begin
    hi_zero = (quo_nxt[ITERS-1:WIDTH-1] == '0);
    res_err = div_zero ||
              (quot_neg_q ? !(hi_zero || (quo_nxt == QuotNegMax)) : !hi_zero);
  end

  assign err = err_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      left_q     <= '0;
      quot_q     <= '0;
      remd_q     <= '0;
      done_q     <= 1'b0;
`ifdef STD_FP_SDIV_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef STD_FP_SDIV_ERR_EN
      err_q  <= 1'b0;
`endif
      unique case (state_q)
        StIdle: begin
          if (go) begin
            quot_neg_q <= left[WIDTH-1] ^ right[WIDTH-1];
            rem_neg_q  <= left[WIDTH-1];
            dvd_q      <= {left_mag, {FRACT_WIDTH{1'b0}}};
            dvs_q      <= {1'b0, right_mag};
            rem_q      <= '0;
            cnt_q      <= '0;
            left_q     <= left;
            state_q    <= StRun;
          end
        end
        StRun: begin
          dvd_q <= quo_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(ITERS - 1)) begin
            quot_q  <= res_quot;
            remd_q  <= res_rem;
            done_q  <= 1'b1;
`ifdef STD_FP_SDIV_ERR_EN
            err_q   <= res_err;
`endif
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_quotient  = quot_q;
  assign out_remainder = remd_q;
  assign done          = done_q;

endmodule

// File: tb/tb_std_fp_sdiv_pipe.sv
// Directed self-checking bench for std_fp_sdiv_pipe (W=32, F=16).
// Checks err only when STD_FP_SDIV_ERR_EN is defined.
module tb_std_fp_sdiv_pipe;

  logic        clk;
  logic        reset;
  logic        go;
  logic [31:0] left;
  logic [31:0] right;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        done;
`ifdef STD_FP_SDIV_ERR_EN
  logic        err;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  std_fp_sdiv_pipe #(
    .WIDTH      (32),
    .INT_WIDTH  (16),
    .FRACT_WIDTH(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .go           (go),
    .left         (left),
    .right        (right),
    .out_quotient (out_quotient),
    .out_remainder(out_remainder),
    .done         (done)
`ifdef STD_FP_SDIV_ERR_EN
    ,
    .err          (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation, scrambles operands after the start edge, and waits for done.
  // lat is the edge count after the start edge (-1 on timeout); q_mid/r_mid sampled mid-run.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic [31:0] q_mid, output logic [31:0] r_mid);
    @(negedge clk);
    left  = a;
    right = b;
    go    = 1'b1;
    @(posedge clk);
    #1;
    go    = 1'b0;
    left  = 32'hDEAD_BEEF;
    right = 32'h0BAD_0BAD;
    lat   = -1;
    q_mid = 'x;
    r_mid = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 24) begin
        q_mid = out_quotient;
        r_mid = out_remainder;
      end
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    go    = 1'b0;
    left  = '0;
    right = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
    else n_pass++;
    n_checks++;
    if (out_quotient !== 32'h0) $display("FAIL reset_quot: got %h expected 0", out_quotient);
    else n_pass++;
    n_checks++;
    if (out_remainder !== 32'h0) $display("FAIL reset_rem: got %h expected 0", out_remainder);
    else n_pass++;
`ifdef STD_FP_SDIV_ERR_EN
    n_checks++;
    if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err);
    else n_pass++;
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Generic directed divide: latency, results, optional err, one-cycle done pulse.
  task automatic test_divide(input string name, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_q, input logic [31:0] exp_r,
                             input logic exp_err, input logic [31:0] prev_q,
                             input logic [31:0] prev_r);
    int          lat;
    logic [31:0] q_mid;
    logic [31:0] r_mid;
    run_op(a, b, lat, q_mid, r_mid);
    n_checks++;
    if (lat !== 48) $display("FAIL %s_latency: got %0d expected 48", name, lat);
    else n_pass++;
    n_checks++;
    if (q_mid !== prev_q || r_mid !== prev_r)
      $display("FAIL %s_hold_in_run: got %h/%h expected %h/%h", name, q_mid, r_mid, prev_q, prev_r);
    else n_pass++;
    n_checks++;
    if (out_quotient !== exp_q)
      $display("FAIL %s_quot: got %h expected %h", name, out_quotient, exp_q);
    else n_pass++;
    n_checks++;
    if (out_remainder !== exp_r)
      $display("FAIL %s_rem: got %h expected %h", name, out_remainder, exp_r);
    else n_pass++;
`ifdef STD_FP_SDIV_ERR_EN
    n_checks++;
    if (err !== exp_err) $display("FAIL %s_err: got %b expected %b", name, err, exp_err);
    else n_pass++;
`else
    if (exp_err === 1'bx) $display("note: unexpected unknown err expectation for %s", name);
`endif
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) $display("FAIL %s_done_pulse: got %b expected 0", name, done);
    else n_pass++;
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_quotient !== 32'h0000_5555 || out_remainder !== 32'h0001_0000 || done !== 1'b0)
        $display("FAIL hold_idle_%0d: got %h/%h/%b expected 00005555/00010000/0", i,
                 out_quotient, out_remainder, done);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    left  = 32'h0006_0000;
    right = 32'h0002_0000;
    go    = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if (done !== 1'b0 || out_quotient !== 32'h0 || out_remainder !== 32'h0)
      $display("FAIL midrun_reset: got %b/%h/%h expected 0/00000000/00000000", done,
               out_quotient, out_remainder);
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    test_divide("after_reset", 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 32'h0, 1'b0,
                32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    @(negedge clk);
    left  = 32'h0006_0000;
    right = 32'h0002_0000;
    go    = 1'b1;
    @(posedge clk);
    #1;
    first = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        first = i;
        break;
      end
    end
    n_checks++;
    if (first !== 48 || out_quotient !== 32'h0003_0000)
      $display("FAIL b2b_first: got %0d/%h expected 48/00030000", first, out_quotient);
    else n_pass++;
    // go stays high; the next operands are captured at the IDLE edge after DONE
    left  = 32'hFFF8_8000;
    right = 32'h0002_0000;
    second = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) begin
        left  = 32'h1234_5678;
        right = 32'h0000_0003;
      end
      if (done) begin
        second = i;
        break;
      end
    end
    go = 1'b0;
    n_checks++;
    if (second !== 50) $display("FAIL b2b_spacing: got %0d expected 50", second);
    else n_pass++;
    n_checks++;
    if (out_quotient !== 32'hFFFC_4000 || out_remainder !== 32'h0)
      $display("FAIL b2b_second: got %h/%h expected fffc4000/00000000", out_quotient,
               out_remainder);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || out_quotient !== 32'hFFFC_4000)
      $display("FAIL b2b_no_third: got %b/%h expected 0/fffc4000", done, out_quotient);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_divide("pos", 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 32'h0, 1'b0,
                32'h0, 32'h0);
    test_divide("neg", 32'hFFF8_8000, 32'h0002_0000, 32'hFFFC_4000, 32'h0, 1'b0,
                32'h0003_0000, 32'h0);
    test_divide("frac", 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 32'h0001_0000, 1'b0,
                32'hFFFC_4000, 32'h0);
    test_hold();
    test_divide("negdiv", 32'h0007_0000, 32'hFFFE_0000, 32'hFFFC_8000, 32'h0, 1'b0,
                32'h0000_5555, 32'h0001_0000);
    test_divide("negrem", 32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 32'hFFFF_0000, 1'b0,
                32'hFFFC_8000, 32'h0);
    test_divide("divzero", 32'h0005_0000, 32'h0, 32'h7FFF_FFFF, 32'h0005_0000, 1'b1,
                32'hFFFF_AAAB, 32'hFFFF_0000);
    test_divide("divzero_neg", 32'hFFFB_0000, 32'h0, 32'h8000_0000, 32'hFFFB_0000, 1'b1,
                32'h7FFF_FFFF, 32'h0005_0000);
    test_divide("overflow", 32'h7FFF_0000, 32'h0000_0001, 32'h0, 32'h0, 1'b1,
                32'h8000_0000, 32'hFFFB_0000);
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/std_fp_sdiv_pipe.md
# std_fp_sdiv_pipe

Sequential signed fixed-point divider, the iterative counterpart to the combinational signed fixed-point multiplier. It computes `left / right` on two's-complement Q(INT_WIDTH.FRACT_WIDTH) operands using a one-bit-per-cycle restoring algorithm. Quotient and remainder use the same format as the operands. It sits in the signed fixed-point primitive library and uses the standard go/done latency-insensitive handshake, so the compiler can schedule it like any other multi-cycle primitive.

## Interface
- `WIDTH`, 32, total operand/result width.
- `INT_WIDTH`, 16, integer bits including sign; must equal `WIDTH - FRACT_WIDTH`.
- `FRACT_WIDTH`, 16, fractional bits.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `go`  input  1  start request; sampled only in IDLE.
- `left`  input  WIDTH  signed dividend; captured on the start edge.
- `right`  input  WIDTH  signed divisor; captured on the start edge.
- `out_quotient`  output  WIDTH  signed quotient. Reset value 0.
- `out_remainder`  output  WIDTH  signed remainder. Reset value 0.
- `done`  output  1  one-cycle completion pulse. Reset value 0.
- `err`  output  1  present only with `STD_FP_SDIV_ERR_EN`. Reset value 0.

## Operation
- Define `ITERS = WIDTH + FRACT_WIDTH`. The state machine has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **Start edge (IDLE, `go`=1):**
  - Record `neg_q = left[W-1] ^ right[W-1]` and `neg_r = left[W-1]`.
  - Load the dividend magnitude `|left| << FRACT_WIDTH` into an ITERS-bit shift register.
  - Load `|right|` as a WIDTH+1-bit unsigned value, so `-2^(W-1)` is represented exactly.
  - Clear the WIDTH+1-bit partial remainder and the step counter, then go to RUN.
- **RUN:** each edge performs one restoring step, most significant dividend bit first.
  - Compute `rem = {rem, next_bit}`.
  - If `rem >= divisor`, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - After step ITERS, go to DONE and register the results.
- **Result rules:**
  - Quotient is truncated toward zero. The remainder takes the sign of the dividend, and its magnitude is always less than `|right|`.
  - `out_quotient` is the low WIDTH bits of the signed quotient. On magnitude overflow it wraps silently.
  - `out_remainder` is the signed remainder of the scaled division `(left<<FRACT_WIDTH) - q*right`.
- **Divide by zero (`right`=0):** the block still runs the full ITERS cycles, so latency stays fixed.
  - `out_quotient` is `0x7FF..F` if `left >= 0`, else `0x800..0`.
  - `out_remainder` is `left`.
- **DONE:** `done` is 1 for exactly one cycle, then the block returns to IDLE.
- **Output hold:** `out_*` hold their values from the DONE cycle until the next DONE overwrites them. Outputs do not change during RUN.
- **Handshake:**
  - `go` is ignored in RUN and DONE.
  - If `go` is still 1 in the IDLE cycle after DONE, a new operation starts; the controller must drop `go` after `done`.
  - Operand changes after the start edge have no effect.
- **Reset:** reset asserted at any time, including mid-RUN, asynchronously returns the block to IDLE. It clears `done`, `err`, `out_*`, the counter and the datapath registers. No partial result is ever presented.

## Timing
- The start edge is E0. RUN steps occur on edges E1..E_ITERS.
- `done` is high in the cycle after E_ITERS, i.e. `ITERS` cycles after the start edge plus one cycle in DONE.
- For the default parameters this is 48 steps: `done` is high after 49 edges.
- Back-to-back operations are possible at a throughput of one per `ITERS + 2` cycles.
- Outputs are registered. No combinational path exists from `go`, `left` or `right` to any output.

## Configuration
- **`STD_FP_SDIV_ERR_EN` defined:** the `err` output port exists.
  - It is valid only in the DONE cycle and 0 otherwise.
  - It is 1 if `right` was 0, or if the true quotient magnitude exceeds the signed WIDTH range (greater than `2^(W-1)-1` for a positive quotient, greater than `2^(W-1)` for a negative one).
- **Undefined:** the port and its logic are absent. Quotient and remainder results are identical either way.

## Test plan
All cases use W=32, F=16.
- `left`=0x00060000 (6.0), `right`=0x00020000 (2.0) -> `out_quotient`=0x00030000, `out_remainder`=0, `done` after 49 edges, `err`=0.
- `left`=0xFFF88000 (-7.5), `right`=0x00020000 -> `out_quotient`=0xFFFC4000 (-3.75), `out_remainder`=0.
- `left`=0x00010000, `right`=0x00030000 -> `out_quotient`=0x00005555, `out_remainder`=0x00010000. Outputs hold across 10 idle cycles with `go`=0.
- `left`=0x00050000, `right`=0 -> `out_quotient`=0x7FFFFFFF, `out_remainder`=0x00050000, `err`=1 (macro on). Same latency as a normal divide.
- `left`=0x7FFF0000, `right`=0x00000001 -> quotient wraps to the low 32 bits, `err`=1 (macro on), no `err` port (macro off).
- Assert `reset` low at step 20 of an operation -> `done`, `out_*`=0 immediately. A fresh `go` afterwards yields the correct 6.0/2.0 result with full latency.
